cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle Moore FSM that sequences the 16-bit RISC datapath.
//  Drives instruction-register load, PC control, register-file read/write addresses, ALU op and memory strobes.
//  Decodes the current instruction word held in the instruction register.
//  Sits between the instruction register/status flags and the datapath, memory and PC.
// PARAMETERS
//  OPW   4   opcode field width, ir[15:12]
//  RAW   4   register address width (D=ir[11:8], S=ir[7:4], T=ir[3:0])
//  ALUW  3   alu_op width
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-high
//  ir         in   16    current instruction word
//  z_flag     in   1     ALU zero flag, registered in datapath
//  mem_ready  in   1     memory read/write completion
//  ir_ld      out  1     load instruction register from memory data
//  pc_inc     out  1     PC <= PC+1
//  pc_ld      out  1     PC <= R[S]
//  d_addr     out  RAW   register-file write address
//  s_addr     out  RAW   read port S
//  t_addr     out  RAW   read port T
//  rf_we      out  1     register-file write enable
//  wb_sel     out  1     0 = ALU result, 1 = memory data
//  alu_op     out  ALUW  0 PASS_S, 1 ADD, 2 SUB, 3 AND, 4 OR
//  addr_sel   out  1     memory address: 0 = PC, 1 = register
//  mem_rd     out  1     memory read strobe
//  mem_wr     out  1     memory write strobe
//  halted     out  1     HALT executed
//  illegal    out  1     undefined opcode trapped
// BEHAVIOUR
//  - Reset, async: state=RESET; all outputs 0.
//  - All outputs are registered and Moore-decoded from the next state.
//  - Opcodes:
//      0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR
//      5 LD   R[D] <= M[R[S]]
//      6 ST   M[R[D]] <= R[S]
//      7 MOV  R[D] <= R[S]
//      8 JMP  PC <= R[S]
//      9 JZ   if z_flag then PC <= R[S]
//      F HALT
//      A-E illegal
//  - RESET -> FETCH: one cycle after reset deasserts.
//  - FETCH: mem_rd=1, addr_sel=0.
//      Holds while mem_ready=0.
//      On mem_ready=1: ir_ld=1, pc_inc=1 for exactly one cycle, then go to DECODE.
//  - DECODE: latch D/S/T fields onto the address outputs; branch on opcode.
//      NOP -> FETCH
//      ALU/MOV -> EXEC
//      LD -> MEM_RD
//      ST -> MEM_WR
//      JMP/JZ -> JUMP
//      F -> HALT
//      A-E -> ILLEGAL
//  - EXEC: set alu_op, then go to WB.
//  - WB: rf_we=1 for 1 cycle (wb_sel=0), then FETCH.
//  - MEM_RD: addr_sel=1, mem_rd=1; hold until mem_ready.
//      Then WB_MEM: rf_we=1, wb_sel=1, one cycle, then FETCH.
//  - MEM_WR: addr_sel=1, mem_wr=1; hold until mem_ready, then FETCH.
//  - JUMP:
//      JMP: pc_ld=1 for one cycle.
//      JZ: pc_ld=z_flag, sampled in JUMP.
//      Then FETCH.
//  - HALT: terminal; halted=1; no strobes. Exit only via reset.
//  - ILLEGAL: terminal; illegal=1; no strobes. Exit only via reset.
//  - Cycles from first FETCH cycle to return to FETCH, with mem_ready=1 on its first cycle:
//      NOP 2, ALU/MOV 4, LD 4, ST 3, JMP/JZ 3.
//    Each wait cycle adds 1.
//  - Invariants:
//      rf_we, pc_ld, pc_inc and ir_ld are never high for more than one cycle per instruction.
//      mem_rd and mem_wr are never high together.
//  - Reset mid-instruction: immediate return to RESET; every strobe drops asynchronously.
//  - Unused encodings of the state register recover to RESET.
// STRUCTURE
//  - Shared package cpu_pkg holds:
//      the opcode localparams (OP_NOP..OP_HALT)
//      the ALU op codes
//      the state enumeration
//      the field-slice positions (OP_HI, D_HI, S_HI, T_HI)
//  - One sub-module, cpu_decode: combinational ir -> {opcode class, alu_op, illegal}.
//  - The FSM and output registers live in cpu_control_unit.
// TESTING
//  1. Reset then instruction 16'h1123 (ADD R1,R2,R3), mem_ready=1
//     -> ir_ld 1 cycle, pc_inc 1 cycle; alu_op=1; rf_we with d_addr=1, s=2, t=3; back to FETCH after 4 cycles.
//  2. LD 16'h5450, mem_ready low for 3 cycles in MEM_RD
//     -> mem_rd held 4 cycles with addr_sel=1; then rf_we=1, wb_sel=1, d_addr=4.
//  3. JZ 16'h9070 with z_flag=0 -> no pc_ld.
//     Repeat with z_flag=1 -> pc_ld exactly 1 cycle with s_addr=7.
//  4. 16'hF000 -> halted=1, all strobes 0 for 20 cycles.
//     16'hB000 -> illegal=1.
//     Reset clears both flags.
//  5. Assert reset during MEM_WR (ST 16'h6120)
//     -> mem_wr drops the same cycle; after release FETCH resumes; no rf_we seen.
//  6. 200 random legal instructions with random mem_ready stalls
//     -> assertions: mem_rd/mem_wr mutual exclusion; single-cycle rf_we/pc_ld/pc_inc/ir_ld.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared opcodes, ALU codes, FSM states and IR field positions
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int OP_HI = 15;
    localparam int D_HI  = 11;
    localparam int S_HI  = 7;
    localparam int T_HI  = 3;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASS_S = 3'd0;
    localparam logic [2:0] ALU_ADD    = 3'd1;
    localparam logic [2:0] ALU_SUB    = 3'd2;
    localparam logic [2:0] ALU_AND    = 3'd3;
    localparam logic [2:0] ALU_OR     = 3'd4;

    typedef enum logic [3:0] {
        ST_RESET   = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_EXEC    = 4'd3,
        ST_WB      = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_WB_MEM  = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_JUMP    = 4'd8,
        ST_HALT    = 4'd9,
        ST_ILLEGAL = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP  = 3'd0,
        CL_ALU  = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_JMP  = 3'd4,
        CL_JZ   = 3'd5,
        CL_HALT = 3'd6,
        CL_ILL  = 3'd7
    } opclass_t;

endpackage

`default_nettype wire

// File: rtl/cpu_decode.sv
// ============================================================================
// cpu_decode : combinational opcode -> {opcode class, alu_op, illegal}
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_decode
    import cpu_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int ALUW = 3
) (
    input  logic [OPW-1:0]  opcode,
    output opclass_t        op_class,
    output logic [ALUW-1:0] alu_op,
    output logic            illegal
);

    always_comb begin
        op_class = CL_ILL;
        alu_op   = ALU_PASS_S;
        illegal  = 1'b1;
        case (opcode)
            OP_NOP:  begin op_class = CL_NOP;  illegal = 1'b0; end
            OP_ADD:  begin op_class = CL_ALU;  alu_op = ALU_ADD; illegal = 1'b0; end
            OP_SUB:  begin op_class = CL_ALU;  alu_op = ALU_SUB; illegal = 1'b0; end
            OP_AND:  begin op_class = CL_ALU;  alu_op = ALU_AND; illegal = 1'b0; end
            OP_OR:   begin op_class = CL_ALU;  alu_op = ALU_OR;  illegal = 1'b0; end
            // MOV rides the ALU path with a pass-through of R[S]
            OP_MOV:  begin op_class = CL_ALU;  alu_op = ALU_PASS_S; illegal = 1'b0; end
            OP_LD:   begin op_class = CL_LD;   illegal = 1'b0; end
            OP_ST:   begin op_class = CL_ST;   illegal = 1'b0; end
            OP_JMP:  begin op_class = CL_JMP;  illegal = 1'b0; end
            OP_JZ:   begin op_class = CL_JZ;   illegal = 1'b0; end
            OP_HALT: begin op_class = CL_HALT; illegal = 1'b0; end
            default: begin op_class = CL_ILL;  illegal = 1'b1; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// cpu_control_unit : multi-cycle Moore sequencer for the 16-bit RISC datapath
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int RAW  = 4,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     ir,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ir_ld,
    output logic            pc_inc,
    output logic            pc_ld,
    output logic [RAW-1:0]  d_addr,
    output logic [RAW-1:0]  s_addr,
    output logic [RAW-1:0]  t_addr,
    output logic            rf_we,
    output logic            wb_sel,
    output logic [ALUW-1:0] alu_op,
    output logic            addr_sel,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            halted,
    output logic            illegal
);

    state_t          r_state;
    state_t          w_next;
    opclass_t        w_class;
    logic [ALUW-1:0] w_alu;
    logic            w_illegal_op;

    cpu_decode #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_decode (
        .opcode   (ir[OP_HI -: OPW]),
        .op_class (w_class),
        .alu_op   (w_alu),
        .illegal  (w_illegal_op)
    );

    always_comb begin
        w_next = ST_RESET;
        case (r_state)
            ST_RESET:   w_next = ST_FETCH;
            ST_FETCH:   w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_illegal_op) begin
                    w_next = ST_ILLEGAL;
                end else begin
                    case (w_class)
                        CL_NOP:        w_next = ST_FETCH;
                        CL_ALU:        w_next = ST_EXEC;
                        CL_LD:         w_next = ST_MEM_RD;
                        CL_ST:         w_next = ST_MEM_WR;
                        CL_JMP, CL_JZ: w_next = ST_JUMP;
                        CL_HALT:       w_next = ST_HALT;
                        default:       w_next = ST_ILLEGAL;
                    endcase
                end
            end
            ST_EXEC:    w_next = ST_WB;
            ST_WB:      w_next = ST_FETCH;
            ST_MEM_RD:  w_next = mem_ready ? ST_WB_MEM : ST_MEM_RD;
            ST_WB_MEM:  w_next = ST_FETCH;
            ST_MEM_WR:  w_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_JUMP:    w_next = ST_FETCH;
            ST_HALT:    w_next = ST_HALT;
            ST_ILLEGAL: w_next = ST_ILLEGAL;
            default:    w_next = ST_RESET;
        endcase
    end

    // Outputs are registered from the next state so each one is glitch-free
    // and valid for the whole cycle the FSM spends in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RESET;
            ir_ld    <= 1'b0;
            pc_inc   <= 1'b0;
            pc_ld    <= 1'b0;
            d_addr   <= '0;
            s_addr   <= '0;
            t_addr   <= '0;
            rf_we    <= 1'b0;
            wb_sel   <= 1'b0;
            alu_op   <= '0;
            addr_sel <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            r_state  <= w_next;
            ir_ld    <= (w_next == ST_DECODE);
            pc_inc   <= (w_next == ST_DECODE);
            // JUMP is only entered from DECODE, so the class is still valid here
            pc_ld    <= (w_next == ST_JUMP) &&
                        ((w_class == CL_JMP) || ((w_class == CL_JZ) && z_flag));
            if (r_state == ST_DECODE) begin
                d_addr <= ir[D_HI -: RAW];
                s_addr <= ir[S_HI -: RAW];
                t_addr <= ir[T_HI -: RAW];
            end
            rf_we    <= (w_next == ST_WB) || (w_next == ST_WB_MEM);
            wb_sel   <= (w_next == ST_WB_MEM);
            // alu_op stays stable through write-back so the result is held
            if (w_next == ST_EXEC) begin
                alu_op <= w_alu;
            end else if (w_next != ST_WB) begin
                alu_op <= '0;
            end
            addr_sel <= (w_next == ST_MEM_RD) || (w_next == ST_MEM_WR);
            mem_rd   <= (w_next == ST_FETCH) || (w_next == ST_MEM_RD);
            mem_wr   <= (w_next == ST_MEM_WR);
            halted   <= (w_next == ST_HALT);
            illegal  <= (w_next == ST_ILLEGAL);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
// tb_cpu_control_unit : vector table, corner sequences and random instructions
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ir = 16'h0000;
    logic        z_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        ir_ld, pc_inc, pc_ld, rf_we, wb_sel, addr_sel;
    logic        mem_rd, mem_wr, halted, illegal;
    logic [3:0]  d_addr, s_addr, t_addr;
    logic [2:0]  alu_op;

    cpu_control_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .ir_ld     (ir_ld),
        .pc_inc    (pc_inc),
        .pc_ld     (pc_ld),
        .d_addr    (d_addr),
        .s_addr    (s_addr),
        .t_addr    (t_addr),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .addr_sel  (addr_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic        z;
        int          fw;
        int          aw;
        int          len;
        int          rf;
        logic        wb;
        logic [2:0]  alu;
        int          pcld;
        int          mrd;
        int          mwr;
        logic [3:0]  d;
        logic [3:0]  s;
        logic [3:0]  t;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // per-instruction observations
    int         obs_len, obs_irld, obs_pcinc, obs_rf, obs_pcld, obs_mrd, obs_mwr;
    logic       obs_wb, obs_timeout;
    logic [2:0] obs_alu;
    logic [3:0] obs_rf_d, obs_pl_s, obs_d, obs_s, obs_t;

    vec_t vt[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {ir_ld, pc_inc, pc_ld, rf_we, mem_rd, mem_wr};
    endfunction

    function automatic logic [25:0] all_outs();
        return {ir_ld, pc_inc, pc_ld, d_addr, s_addr, t_addr, rf_we, wb_sel,
                alu_op, addr_sel, mem_rd, mem_wr, halted, illegal};
    endfunction

    task automatic do_reset(input string nm);
        reset = 1'b1;
        mem_ready = 1'b0;
        step();
        step();
        chk(nm, "outs_in_reset", 32'(all_outs()), 32'h0);
        reset = 1'b0;
        step();
        chk(nm, "first_fetch", {28'h0, mem_rd, addr_sel, ir_ld, rf_we}, 32'b1000);
    endtask

    // Runs one instruction starting at its first FETCH cycle; a simple memory
    // responder answers after fw (fetch) or aw (data access) wait cycles.
    task automatic run_one(input string nm, input logic [15:0] instr,
                           input logic z, input int fw, input int aw);
        int   fcnt = 0;
        int   acnt = 0;
        int   cyc = 0;
        logic left = 1'b0;
        logic [5:0] prev = 6'h0;
        ir = instr;
        z_flag = z;
        obs_irld = 0; obs_pcinc = 0; obs_rf = 0; obs_pcld = 0;
        obs_mrd = 0; obs_mwr = 0; obs_wb = 1'b0; obs_alu = 3'h0;
        obs_rf_d = 4'h0; obs_pl_s = 4'h0; obs_timeout = 1'b0;
        while (1) begin
            if (mem_rd && !addr_sel && left) break;
            if (!(mem_rd && !addr_sel)) left = 1'b1;
            if (cyc >= 60) begin
                obs_timeout = 1'b1;
                break;
            end
            chk(nm, "mutex", {31'h0, mem_rd & mem_wr}, 32'h0);
            chk(nm, "one_cycle", {26'h0, strobes() & prev & 6'b111100}, 32'h0);
            prev = strobes();
            obs_irld  += int'(ir_ld);
            obs_pcinc += int'(pc_inc);
            obs_mrd   += int'(mem_rd);
            obs_mwr   += int'(mem_wr);
            if (rf_we) begin
                obs_rf++;
                obs_wb   = wb_sel;
                obs_alu  = alu_op;
                obs_rf_d = d_addr;
            end
            if (pc_ld) begin
                obs_pcld++;
                obs_pl_s = s_addr;
            end
            if (mem_rd || mem_wr) begin
                if (!addr_sel) begin
                    mem_ready = (fcnt >= fw);
                    fcnt++;
                end else begin
                    mem_ready = (acnt >= aw);
                    acnt++;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            step();
            cyc++;
        end
        obs_len = cyc;
        obs_d = d_addr;
        obs_s = s_addr;
        obs_t = t_addr;
    endtask

    // Expected behaviour from the instruction set: fetch+decode take two
    // cycles, ALU/MOV add execute and write-back, loads add a read plus
    // write-back, stores add a write, jumps add one; every wait adds one.
    function automatic vec_t model(input logic [15:0] instr, input logic z,
                                   input int fw, input int aw);
        vec_t e;
        int   op;
        op = int'(instr[15:12]);
        e.ir = instr; e.z = z; e.fw = fw; e.aw = aw;
        e.d = instr[11:8]; e.s = instr[7:4]; e.t = instr[3:0];
        e.len = 2 + fw; e.mrd = 1 + fw; e.mwr = 0;
        e.rf = 0; e.wb = 1'b0; e.alu = 3'd0; e.pcld = 0;
        if (op >= 1 && op <= 4) begin
            e.len += 2; e.rf = 1; e.alu = 3'(op);
        end else if (op == 7) begin
            e.len += 2; e.rf = 1; e.alu = 3'd0;
        end else if (op == 5) begin
            e.len += 2 + aw; e.rf = 1; e.wb = 1'b1; e.mrd += 1 + aw;
        end else if (op == 6) begin
            e.len += 1 + aw; e.mwr = 1 + aw;
        end else if (op == 8) begin
            e.len += 1; e.pcld = 1;
        end else if (op == 9) begin
            e.len += 1; e.pcld = int'(z);
        end
        return e;
    endfunction

    task automatic compare(input string nm, input vec_t e);
        chk(nm, "timeout", {31'h0, obs_timeout}, 32'h0);
        chk(nm, "cycles", obs_len, e.len);
        chk(nm, "ir_ld_cnt", obs_irld, 1);
        chk(nm, "pc_inc_cnt", obs_pcinc, 1);
        chk(nm, "rf_we_cnt", obs_rf, e.rf);
        if (e.rf != 0) begin
            chk(nm, "wb_sel", {31'h0, obs_wb}, {31'h0, e.wb});
            chk(nm, "rf_d_addr", {28'h0, obs_rf_d}, {28'h0, e.d});
            if (!e.wb) chk(nm, "alu_op", {29'h0, obs_alu}, {29'h0, e.alu});
        end
        chk(nm, "pc_ld_cnt", obs_pcld, e.pcld);
        if (e.pcld != 0) chk(nm, "pc_ld_s", {28'h0, obs_pl_s}, {28'h0, e.s});
        chk(nm, "mem_rd_cyc", obs_mrd, e.mrd);
        chk(nm, "mem_wr_cyc", obs_mwr, e.mwr);
        chk(nm, "dst", {20'h0, obs_d, obs_s, obs_t}, {20'h0, e.d, e.s, e.t});
        if (obs_timeout) do_reset("resync");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           ir     z     fw aw len rf wb    alu  pcld mrd mwr d      s      t
        vt[0]  = '{16'h1123, 1'b0, 0, 0, 4, 1, 1'b0, 3'd1, 0, 1, 0, 4'd1,  4'd2,  4'd3};
        vt[1]  = '{16'h1123, 1'b0, 2, 0, 6, 1, 1'b0, 3'd1, 0, 3, 0, 4'd1,  4'd2,  4'd3};
        vt[2]  = '{16'h2456, 1'b0, 0, 0, 4, 1, 1'b0, 3'd2, 0, 1, 0, 4'd4,  4'd5,  4'd6};
        vt[3]  = '{16'h3789, 1'b0, 0, 0, 4, 1, 1'b0, 3'd3, 0, 1, 0, 4'd7,  4'd8,  4'd9};
        vt[4]  = '{16'h4abc, 1'b1, 0, 0, 4, 1, 1'b0, 3'd4, 0, 1, 0, 4'd10, 4'd11, 4'd12};
        vt[5]  = '{16'h7e10, 1'b0, 0, 0, 4, 1, 1'b0, 3'd0, 0, 1, 0, 4'd14, 4'd1,  4'd0};
        vt[6]  = '{16'h5450, 1'b0, 0, 3, 7, 1, 1'b1, 3'd0, 0, 5, 0, 4'd4,  4'd5,  4'd0};
        vt[7]  = '{16'h6120, 1'b0, 0, 1, 4, 0, 1'b0, 3'd0, 0, 1, 2, 4'd1,  4'd2,  4'd0};
        vt[8]  = '{16'h8030, 1'b0, 0, 0, 3, 0, 1'b0, 3'd0, 1, 1, 0, 4'd0,  4'd3,  4'd0};
        vt[9]  = '{16'h9070, 1'b0, 0, 0, 3, 0, 1'b0, 3'd0, 0, 1, 0, 4'd0,  4'd7,  4'd0};
        vt[10] = '{16'h9070, 1'b1, 0, 0, 3, 0, 1'b0, 3'd0, 1, 1, 0, 4'd0,  4'd7,  4'd0};
        vt[11] = '{16'h0000, 1'b0, 1, 0, 3, 0, 1'b0, 3'd0, 0, 2, 0, 4'd0,  4'd0,  4'd0};
        vt[12] = '{16'h5450, 1'b0, 1, 0, 5, 1, 1'b1, 3'd0, 0, 3, 0, 4'd4,  4'd5,  4'd0};

        do_reset("reset");

        for (int i = 0; i < 13; i++) begin
            run_one($sformatf("vec%0d", i), vt[i].ir, vt[i].z, vt[i].fw, vt[i].aw);
            compare($sformatf("vec%0d", i), vt[i]);
        end

        // HALT is terminal: flag up, every strobe quiet until reset
        ir = 16'hF000; mem_ready = 1'b1;
        step();
        chk("halt", "ir_ld", {31'h0, ir_ld}, 32'h1);
        step();
        for (int i = 0; i < 20; i++) begin
            chk("halt", "flag", {31'h0, halted}, 32'h1);
            chk("halt", "strobes", {26'h0, strobes()}, 32'h0);
            mem_ready = 1'($urandom_range(0, 1));
            step();
        end
        do_reset("halt_clr");
        chk("halt_clr", "flag", {31'h0, halted}, 32'h0);

        ir = 16'hB000; mem_ready = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("illegal", "flags", {30'h0, illegal, halted}, 32'b10);
            chk("illegal", "strobes", {26'h0, strobes()}, 32'h0);
            step();
        end
        do_reset("illegal_clr");
        chk("illegal_clr", "flag", {31'h0, illegal}, 32'h0);

        // reset asserted mid-store must kill mem_wr without waiting for a clock
        ir = 16'h6120; z_flag = 1'b0; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        chk("st_reset", "mem_wr_before", {31'h0, mem_wr}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("st_reset", "async_drop", 32'(all_outs()), 32'h0);
        step();
        chk("st_reset", "rf_we_in_reset", {31'h0, rf_we}, 32'h0);
        reset = 1'b0;
        step();
        chk("st_reset", "resume", {28'h0, mem_rd, addr_sel, rf_we, mem_wr}, 32'b1000);

        for (int n = 0; n < 200; n++) begin
            logic [15:0] instr;
            logic        z;
            int          fw, aw;
            instr = {4'($urandom_range(0, 9)), 12'($urandom)};
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            aw = $urandom_range(0, 3);
            run_one($sformatf("rand%0d", n), instr, z, fw, aw);
            compare($sformatf("rand%0d_%h", n, instr), model(instr, z, fw, aw));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
